// File: rtl/shift_delay_line.sv
// Parametrised WIDTH x DEPTH delay line. It provides a stall enable, a flush, per-stage valid bits,
// a runtime output tap select, an occupancy counter and a full-tap export.
module shift_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       d,
  input  logic                   d_valid,
  input  logic [SELW-1:0]        dly_sel,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [SELW-1:0]        occ,
  output logic                   full,
  output logic                   sel_err
);

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [SELW-1:0]  occ_q, occ_d;
  logic             sel_ok;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stg_d[i] = stg_q[i];
    vld_d = vld_q;
    occ_d = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) stg_d[i] = '0;
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      stg_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stg_d[i] = stg_q[i-1];
      vld_d = {vld_q[DEPTH-2:0], d_valid};
      // A sample entering while the last stage drops a valid leaves the count unchanged.
      if (d_valid && !vld_q[DEPTH-1])      occ_d = occ_q + SELW'(1);
      else if (!d_valid && vld_q[DEPTH-1]) occ_d = occ_q - SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= stg_d[i];
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  // Out-of-range selects fall back to the deepest tap.
  always_comb begin
    q       = stg_q[DEPTH-1];
    q_valid = vld_q[DEPTH-1];
    sel_ok  = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (dly_sel == SELW'(k)) begin
        q       = stg_q[k-1];
        q_valid = vld_q[k-1];
        sel_ok  = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_taps
    assign taps[i*WIDTH +: WIDTH] = stg_q[i];
  end

  assign occ     = occ_q;
  assign full    = (occ_q == SELW'(DEPTH));
  assign sel_err = !sel_ok;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (int'(occ_q) == $countones(vld_q))
      else $error("occ %0d disagrees with valid bits %b", occ_q, vld_q);
  end
`endif

endmodule

// File: tb/tb_shift_delay_line.sv
// Bench for shift_delay_line. It drives a legacy-sized instance (1x3) and a wide instance (8x5)
// through table vectors, a queue scoreboard and hand-written stall and flush sequences.
module tb_shift_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Legacy-sized instance
  logic       rst3, en3, fl3, d3, dv3, q3, qv3, full3, serr3;
  logic [1:0] sel3, occ3;
  logic [2:0] taps3;

  // Wide instance
  logic        rst5, en5, fl5, dv5, qv5, full5, serr5;
  logic [7:0]  d5, q5;
  logic [2:0]  sel5, occ5;
  logic [39:0] taps5;

  shift_delay_line #(.WIDTH(1), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst3), .en(en3), .flush(fl3), .d(d3), .d_valid(dv3), .dly_sel(sel3),
    .q(q3), .q_valid(qv3), .taps(taps3), .occ(occ3), .full(full3), .sel_err(serr3)
  );

  shift_delay_line #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst5), .en(en5), .flush(fl5), .d(d5), .d_valid(dv5), .dly_sel(sel5),
    .q(q5), .q_valid(qv5), .taps(taps5), .occ(occ5), .full(full5), .sel_err(serr5)
  );

  int checks = 0;
  int errors = 0;

  // Each entry is {valid, data} for the deepest tap of the wide instance.
  logic [8:0] exp_q[$];

  typedef struct {
    logic       d;
    logic       exp_q;
    logic [1:0] exp_occ;
    logic       exp_full;
  } leg_vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp_q;
    logic       exp_err;
  } tap_vec_t;

  leg_vec_t leg_tbl[8];
  tap_vec_t tap_tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush5();
    fl5 = 1'b1;
    tick();
    fl5 = 1'b0;
    exp_q.delete();
    repeat (4) exp_q.push_back(9'h0);
  endtask

  // One enabled edge on the wide instance. The tap at dly_sel = 5 is checked against the scoreboard.
  task automatic step5(input logic [7:0] dv_d, input logic dv);
    logic [8:0] e;
    d5  = dv_d;
    dv5 = dv;
    exp_q.push_back({dv, dv_d});
    tick();
    e = exp_q.pop_front();
    check("sb_q5", {55'h0, qv5, q5}, {55'h0, e});
  endtask

  initial begin
    rst3 = 1'b1; en3 = 1'b1; fl3 = 1'b0; d3 = 1'b0; dv3 = 1'b1; sel3 = 2'd3;
    rst5 = 1'b1; en5 = 1'b1; fl5 = 1'b0; d5 = 8'h0; dv5 = 1'b0; sel5 = 3'd5;

    // Legacy equivalence
    leg_tbl[0] = '{1'b0, 1'b0, 2'd1, 1'b0};
    leg_tbl[1] = '{1'b1, 1'b0, 2'd2, 1'b0};
    leg_tbl[2] = '{1'b0, 1'b0, 2'd3, 1'b1};
    leg_tbl[3] = '{1'b1, 1'b1, 2'd3, 1'b1};
    leg_tbl[4] = '{1'b1, 1'b0, 2'd3, 1'b1};
    leg_tbl[5] = '{1'b1, 1'b1, 2'd3, 1'b1};
    leg_tbl[6] = '{1'b1, 1'b1, 2'd3, 1'b1};
    leg_tbl[7] = '{1'b1, 1'b1, 2'd3, 1'b1};

    tick();
    check("rst_q3", 64'(q3), 64'h0);
    check("rst_occ3", 64'(occ3), 64'h0);
    check("rst_q5", 64'(q5), 64'h0);
    check("rst_taps5", 64'(taps5), 64'h0);
    rst3 = 1'b0;
    rst5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d3 = leg_tbl[i].d;
      tick();
      check("leg_q", 64'(q3), 64'(leg_tbl[i].exp_q));
      check("leg_occ", 64'(occ3), 64'(leg_tbl[i].exp_occ));
      check("leg_full", 64'(full3), 64'(leg_tbl[i].exp_full));
    end

    // Tap sweep
    tap_tbl[0] = '{3'd1, 8'h55, 1'b0};
    tap_tbl[1] = '{3'd2, 8'h44, 1'b0};
    tap_tbl[2] = '{3'd3, 8'h33, 1'b0};
    tap_tbl[3] = '{3'd4, 8'h22, 1'b0};
    tap_tbl[4] = '{3'd5, 8'h11, 1'b0};
    tap_tbl[5] = '{3'd0, 8'h11, 1'b1};
    tap_tbl[6] = '{3'd6, 8'h11, 1'b1};
    tap_tbl[7] = '{3'd7, 8'h11, 1'b1};
    flush5();
    check("flush_occ5", 64'(occ5), 64'h0);
    for (int i = 1; i <= 5; i++) step5(8'(i * 8'h11), 1'b1);
    for (int i = 0; i < 8; i++) begin
      sel5 = tap_tbl[i].sel;
      #1;
      check("tap_q", 64'(q5), 64'(tap_tbl[i].exp_q));
      check("tap_err", 64'(serr5), 64'(tap_tbl[i].exp_err));
      check("tap_taps0", 64'(taps5[7:0]), 64'h55);
    end

    // Stall
    flush5();
    sel5 = 3'd2;
    d5 = 8'hA1; dv5 = 1'b1;
    tick();
    check("stall_load_taps", 64'(taps5), 64'hA1);
    en5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d5 = 8'($urandom_range(0, 255));
      dv5 = 1'($urandom_range(0, 1));
      tick();
      check("stall_q", 64'(q5), 64'h0);
      check("stall_taps", 64'(taps5), 64'hA1);
      check("stall_occ", 64'(occ5), 64'h1);
    end
    en5 = 1'b1; d5 = 8'h0; dv5 = 1'b0;
    tick();
    check("stall_out_q", 64'({qv5, q5}), 64'h1A1);
    check("stall_out_occ", 64'(occ5), 64'h1);

    // Bubbles and occupancy
    sel5 = 3'd5;
    flush5();
    begin
      logic       bub_dv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] bub_occ[9] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};
      for (int i = 0; i < 9; i++) begin
        step5(8'($urandom_range(0, 255)), bub_dv[i]);
        check("bub_occ", 64'(occ5), 64'(bub_occ[i]));
        check("bub_full", 64'(full5), 64'h0);
      end
    end

    // Saturation
    flush5();
    for (int n = 1; n <= 15; n++) begin
      step5(8'($urandom_range(0, 255)), 1'b1);
      check("sat_occ", 64'(occ5), 64'((n < 5) ? n : 5));
      check("sat_full", 64'(full5), 64'(n >= 5));
    end

    // Flush mid-stream while a valid sample is offered
    fl5 = 1'b1; d5 = 8'hFF; dv5 = 1'b1;
    tick();
    fl5 = 1'b0;
    check("fl_occ", 64'(occ5), 64'h0);
    check("fl_taps", 64'(taps5), 64'h0);
    check("fl_qv", 64'(qv5), 64'h0);
    check("fl_full", 64'(full5), 64'h0);
    repeat (5) begin
      d5 = 8'($urandom_range(0, 255));
      tick();
    end
    check("refill_occ", 64'(occ5), 64'h5);
    rst5 = 1'b1; fl5 = 1'b1;
    tick();
    rst5 = 1'b0; fl5 = 1'b0;
    check("rstfl_occ", 64'(occ5), 64'h0);
    check("rstfl_taps", 64'(taps5), 64'h0);
    check("rstfl_qv", 64'(qv5), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
